// File: rtl/interp_feed_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : interp_feed_ctrl
// Purpose  : Input FIFO and frame sequencer feeding a polyphase interpolation
//            FIR: one input sample per OSF phases, each phase lasting CPP clocks.
// Options  : define INTERP_FEED_CTRL_UNDERRUN_ZERO_EN to insert zero samples on
//            starvation instead of dropping back to idle.
// Revision : 1.0 - initial release
// ============================================================================
module interp_feed_ctrl #(
    parameter int OSF   = 16,
    parameter int CPP   = 8,
    parameter int DEPTH = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      enable,
    input  logic signed [15:0]        in_sample,
    input  logic                      in_valid,
    output logic                      in_ready,
    output logic signed [15:0]        fir_in,
    output logic                      FIR_en,
    output logic [4:0]                FIR_sel,
    input  logic signed [17:0]        fir_out,
    output logic signed [17:0]        out_sample,
    output logic                      out_valid,
    output logic                      underrun,
    output logic [$clog2(DEPTH):0]    fifo_level
);

    localparam int               c_ADDR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int               c_LVL_W   = $clog2(DEPTH) + 1;
    localparam int               c_TMR_W   = (CPP > 1) ? $clog2(CPP) : 1;
    localparam logic [4:0]       c_PH_LAST = 5'(OSF - 1);
    localparam logic [c_TMR_W-1:0] c_T_LAST = c_TMR_W'(CPP - 1);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_RUN  = 1'b1;

    logic [0:0]          r_state;
    logic [4:0]          r_phase;
    logic [c_TMR_W-1:0]  r_timer;
    logic [15:0]         r_mem [DEPTH];
    logic [c_ADDR_W-1:0] r_wr_ptr;
    logic [c_ADDR_W-1:0] r_rd_ptr;
    logic [c_LVL_W-1:0]  r_count;
    logic [15:0]         r_fir_in;
    logic                r_fir_en;
    logic [17:0]         r_out_sample;
    logic                r_out_valid;
    logic                r_underrun;

    logic w_full, w_empty, w_push, w_pop, w_start, w_wrap, w_boundary;
    logic [15:0] w_head;

    function automatic logic [c_ADDR_W-1:0] f_next(input logic [c_ADDR_W-1:0] p);
        return (p == c_ADDR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign w_full     = (r_count == c_LVL_W'(DEPTH));
    assign w_empty    = (r_count == '0);
    assign w_head     = r_mem[r_rd_ptr];
    assign w_push     = in_valid && in_ready;
    assign w_start    = (r_state == S_IDLE) && enable && !w_empty;
    assign w_wrap     = (r_state == S_RUN) && (r_timer == c_T_LAST);
    assign w_boundary = w_wrap && (r_phase == c_PH_LAST);
    // The FIFO is only read when a new frame begins, so input arriving mid-frame
    // never disturbs the sample currently in the FIR.
    assign w_pop      = w_start || (w_boundary && enable && !w_empty);

    // Held low through reset so nothing is accepted into a FIFO being cleared.
    assign in_ready   = !rst && !w_full;

    assign fir_in     = r_fir_in;
    assign FIR_en     = r_fir_en;
    assign FIR_sel    = r_phase;
    assign out_sample = r_out_sample;
    assign out_valid  = r_out_valid;
    assign underrun   = r_underrun;
    assign fifo_level = r_count;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= in_sample;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= f_next(r_wr_ptr);
            end
            if (w_pop) begin
                r_rd_ptr <= f_next(r_rd_ptr);
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + 1'b1;
            end else if (!w_push && w_pop) begin
                r_count <= r_count - 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_phase      <= '0;
            r_timer      <= '0;
            r_fir_in     <= '0;
            r_fir_en     <= 1'b0;
            r_out_sample <= '0;
            r_out_valid  <= 1'b0;
            r_underrun   <= 1'b0;
        end else begin
            r_fir_en    <= 1'b0;
            r_out_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_phase <= '0;
                    r_timer <= '0;
                    if (w_start) begin
                        r_fir_in <= w_head;
                        r_fir_en <= 1'b1;
                        r_state  <= S_RUN;
                    end
                end
                default: begin
                    if (w_wrap) begin
                        r_timer      <= '0;
                        r_out_sample <= fir_out;
                        r_out_valid  <= 1'b1;
                        if (w_boundary) begin
                            r_phase <= '0;
                            if (!enable) begin
                                r_state <= S_IDLE;
                            end else if (!w_empty) begin
                                r_fir_in <= w_head;
                                r_fir_en <= 1'b1;
                            end else begin
                                r_underrun <= 1'b1;
`ifdef INTERP_FEED_CTRL_UNDERRUN_ZERO_EN
                                r_fir_in   <= '0;
                                r_fir_en   <= 1'b1;
`else
                                r_state    <= S_IDLE;
`endif
                            end
                        end else begin
                            r_phase <= r_phase + 1'b1;
                        end
                    end else begin
                        r_timer <= r_timer + 1'b1;
                    end
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_interp_feed_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_interp_feed_ctrl
// Purpose  : Scoreboard bench for interp_feed_ctrl with a stub FIR that
//            returns fir_in + FIR_sel so every output phase is identifiable.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_interp_feed_ctrl;

    localparam int OSF   = 16;
    localparam int CPP   = 8;
    localparam int DEPTH = 4;
    localparam int FRAME = OSF * CPP;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        enable = 1'b0;
    logic [15:0] in_sample = '0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] fir_in;
    logic        FIR_en;
    logic [4:0]  FIR_sel;
    logic [17:0] fir_out;
    logic [17:0] out_sample;
    logic        out_valid;
    logic        underrun;
    logic [$clog2(DEPTH):0] fifo_level;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int n_valid = 0;
    int nv0;
    int acc;

    logic [17:0] exp_q[$];
    logic [15:0] fen_q[$];
    int          fen_times[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    assign fir_out = {{2{fir_in[15]}}, fir_in} + {13'd0, FIR_sel};

    interp_feed_ctrl #(.OSF(OSF), .CPP(CPP), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .enable(enable),
        .in_sample(in_sample), .in_valid(in_valid), .in_ready(in_ready),
        .fir_in(fir_in), .FIR_en(FIR_en), .FIR_sel(FIR_sel), .fir_out(fir_out),
        .out_sample(out_sample), .out_valid(out_valid),
        .underrun(underrun), .fifo_level(fifo_level)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [15:0] s);
        in_sample = s;
        in_valid  = 1'b1;
        tick(1);
        in_valid  = 1'b0;
    endtask

    // One frame: a load of s, then OSF outputs of s + phase.
    task automatic expect_frame(input logic [15:0] s);
        fen_q.push_back(s);
        for (int k = 0; k < OSF; k++) exp_q.push_back({{2{s[15]}}, s} + 18'(k));
    endtask

    task automatic wait_drain(input string name, input int budget);
        int n = 0;
        while ((exp_q.size() != 0 || fen_q.size() != 0) && n < budget) begin
            tick(1);
            n++;
        end
        chk(name, 32'(exp_q.size() + fen_q.size()), 0);
    endtask

    task automatic wait_fen(input string name, input int cnt, input int budget);
        int n = 0;
        while (fen_times.size() < cnt && n < budget) begin
            tick(1);
            n++;
        end
        chk(name, 32'(fen_times.size()), 32'(cnt));
    endtask

    always @(negedge clk) begin
        if (out_valid === 1'b1) begin
            n_valid++;
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL out_unexpected got pulse %h expected none", out_sample);
            end else begin
                chk("out_sample", 32'(out_sample), 32'(exp_q.pop_front()));
            end
        end
        if (FIR_en === 1'b1) begin
            fen_times.push_back(cyc);
            if (fen_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL fen_unexpected got load %h expected none", fir_in);
            end else begin
                chk("fir_in_load", 32'(fir_in), 32'(fen_q.pop_front()));
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        tick(3);
        chk("rst_in_ready", 32'(in_ready), 0);
        chk("rst_level", 32'(fifo_level), 0);
        chk("rst_fir_en", 32'(FIR_en), 0);
        chk("rst_fir_sel", 32'(FIR_sel), 0);
        chk("rst_fir_in", 32'(fir_in), 0);
        chk("rst_out", 32'(out_sample), 0);
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_underrun", 32'(underrun), 0);
        rst = 1'b0;
        tick(1);
        chk("ready_after_rst", 32'(in_ready), 1);

        // Full FIFO with enable low: fifth sample refused
        acc = 0;
        for (int i = 0; i < 5; i++) begin
            in_sample = 16'(16'h1000 * (i + 1));
            in_valid  = 1'b1;
            if (in_ready) acc++;
            tick(1);
        end
        in_valid = 1'b0;
        chk("full_accepted", 32'(acc), 4);
        chk("full_level", 32'(fifo_level), 4);
        chk("full_ready", 32'(in_ready), 0);
        for (int i = 0; i < 4; i++) expect_frame(16'(16'h1000 * (i + 1)));
        fen_times.delete();
        enable = 1'b1;
        wait_fen("full_loads", 4, 5 * FRAME);
        enable = 1'b0;
        wait_drain("full_drain", 2 * FRAME);
        chk("full_gap", 32'(fen_times[3] - fen_times[2]), FRAME);
        chk("full_level_end", 32'(fifo_level), 0);

        // Continuous stream of three pre-loaded samples
        push(16'h0100);
        push(16'h0200);
        push(16'hF300);
        expect_frame(16'h0100);
        expect_frame(16'h0200);
        expect_frame(16'hF300);
        nv0 = n_valid;
        fen_times.delete();
        enable = 1'b1;
        wait_fen("cont_loads", 3, 4 * FRAME);
        enable = 1'b0;
        wait_drain("cont_drain", 2 * FRAME);
        chk("cont_gap1", 32'(fen_times[1] - fen_times[0]), FRAME);
        chk("cont_gap2", 32'(fen_times[2] - fen_times[1]), FRAME);
        chk("cont_pulses", 32'(n_valid - nv0), 48);
        chk("cont_underrun", 32'(underrun), 0);

        // Single sample: FIR_sel stepping
        nv0 = n_valid;
        enable = 1'b1;
        expect_frame(16'h4000);
        push(16'h4000);
        chk("single_no_early_load", 32'(FIR_en), 0);
        tick(1);
        chk("single_load", 32'(FIR_en), 1);
        chk("single_sel0", 32'(FIR_sel), 0);
        tick(3 * CPP);
        chk("single_sel3", 32'(FIR_sel), 3);
        tick(CPP - 1);
        chk("single_sel3_hold", 32'(FIR_sel), 3);
        tick(1);
        chk("single_sel4", 32'(FIR_sel), 4);
        tick(11 * CPP);
        chk("single_sel15", 32'(FIR_sel), 15);
        enable = 1'b0;
        wait_drain("single_drain", 2 * FRAME);
        tick(2);
        chk("single_pulses", 32'(n_valid - nv0), 16);
        chk("single_idle_sel", 32'(FIR_sel), 0);
        chk("single_underrun", 32'(underrun), 0);

        // Starvation with enable held high
        nv0 = n_valid;
        fen_times.delete();
        enable = 1'b1;
        expect_frame(16'h7FF0);
`ifdef INTERP_FEED_CTRL_UNDERRUN_ZERO_EN
        expect_frame(16'h0000);
`endif
        push(16'h7FF0);
        tick(1);
        chk("starve_load", 32'(FIR_en), 1);
        tick(FRAME / 2);
        chk("starve_mid_underrun", 32'(underrun), 0);
`ifdef INTERP_FEED_CTRL_UNDERRUN_ZERO_EN
        wait_fen("starve_zero_load", 2, FRAME);
        enable = 1'b0;
        wait_drain("starve_drain", 2 * FRAME);
        chk("starve_underrun", 32'(underrun), 1);
        chk("starve_gap", 32'(fen_times[1] - fen_times[0]), FRAME);
        chk("starve_pulses", 32'(n_valid - nv0), 32);
`else
        wait_drain("starve_drain", 2 * FRAME);
        tick(2);
        chk("starve_underrun", 32'(underrun), 1);
        chk("starve_idle_sel", 32'(FIR_sel), 0);
        tick(FRAME + 10);
        chk("starve_loads", 32'(fen_times.size()), 1);
        chk("starve_pulses", 32'(n_valid - nv0), 16);
        enable = 1'b0;
`endif
        tick(1);
        chk("underrun_sticky", 32'(underrun), 1);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        chk("underrun_cleared", 32'(underrun), 0);
        tick(1);

        // Enable dropped at phase 5: frame completes, new input waits
        nv0 = n_valid;
        enable = 1'b1;
        expect_frame(16'h1234);
        push(16'h1234);
        tick(1);
        chk("drop_load", 32'(FIR_en), 1);
        tick(5 * CPP);
        chk("drop_sel5", 32'(FIR_sel), 5);
        enable = 1'b0;
        push(16'h5678);
        tick(FRAME - 5 * CPP - 1);
        tick(2);
        chk("drop_idle_sel", 32'(FIR_sel), 0);
        chk("drop_level", 32'(fifo_level), 1);
        wait_drain("drop_drain", FRAME);
        chk("drop_pulses", 32'(n_valid - nv0), 16);

        // Reset at phase 9 aborts the frame
        expect_frame(16'h5678);
        enable = 1'b1;
        tick(1);
        chk("abort_load", 32'(FIR_en), 1);
        tick(9 * CPP + 3);
        chk("abort_sel9", 32'(FIR_sel), 9);
        rst = 1'b1;
        exp_q.delete();
        fen_q.delete();
        nv0 = n_valid;
        tick(1);
        chk("abort_fir_in", 32'(fir_in), 0);
        chk("abort_fir_en", 32'(FIR_en), 0);
        chk("abort_sel", 32'(FIR_sel), 0);
        chk("abort_out", 32'(out_sample), 0);
        chk("abort_out_valid", 32'(out_valid), 0);
        chk("abort_underrun", 32'(underrun), 0);
        chk("abort_level", 32'(fifo_level), 0);
        chk("abort_ready", 32'(in_ready), 0);
        tick(1);
        chk("abort_out_valid2", 32'(out_valid), 0);
        rst = 1'b0;
        enable = 1'b0;
        tick(2 * CPP);
        chk("abort_no_pulses", 32'(n_valid - nv0), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/interp_feed_ctrl.md
INTERP_FEED_CTRL -- requirements
Module: interp_feed_ctrl

Interface
REQ-001 SHALL have parameter OSF, default 16, the interpolation factor (phases per input sample).
REQ-002 SHALL have parameter CPP, default 8, the clocks per output phase; legal values are 6 or more.
REQ-003 SHALL have parameter DEPTH, default 4, the input FIFO depth; legal values are powers of two.
REQ-004 SHALL have port clk, input, 1 bit, the clock; reset is rst, synchronous, active-high.
REQ-005 SHALL have port rst, input, 1 bit, the synchronous active-high reset.
REQ-006 SHALL have port enable, input, 1 bit, which permits new frames to start.
REQ-007 SHALL have port in_sample, input, 16 bits, the signed input sample.
REQ-008 SHALL have port in_valid, input, 1 bit, which qualifies in_sample.
REQ-009 SHALL have port in_ready, output, 1 bit, equal to !fifo_full.
REQ-010 SHALL have port fir_in, output, 16 bits, the signed sample driven to the polyphase FIR.
REQ-011 SHALL have port FIR_en, output, 1 bit, the one-cycle FIR shift strobe.
REQ-012 SHALL have port FIR_sel, output, 5 bits, the phase index in the range 0..OSF-1.
REQ-013 SHALL have port fir_out, input, 18 bits, the signed FIR result.
REQ-014 SHALL have port out_sample, output, 18 bits, the captured interpolated sample.
REQ-015 SHALL have port out_valid, output, 1 bit, a one-cycle pulse per out_sample.
REQ-016 SHALL have port underrun, output, 1 bit, a sticky starvation flag.
REQ-017 SHALL have port fifo_level, output, clog2(DEPTH)+1 bits, the FIFO occupancy.

Function
REQ-018 SHALL push in_sample into the FIFO when in_valid && in_ready; simultaneous push and pop leaves fifo_level unchanged; pointers wrap modulo DEPTH.
REQ-019 SHALL implement two states, IDLE and RUN, with counters phase (0..OSF-1) and timer (0..CPP-1).
REQ-020 In IDLE, SHALL hold FIR_en=0, FIR_sel=0 and timer=0, and SHALL hold fir_in at its last value.
REQ-021 IDLE->RUN SHALL occur when enable=1 and the FIFO is non-empty; in that same cycle the block pops the FIFO head into fir_in, pulses FIR_en, and sets phase=0 and timer=0.
REQ-022 In RUN, timer SHALL increment each clock; at timer=CPP-1 it wraps to 0 and phase increments.
REQ-023 FIR_sel SHALL equal phase, and SHALL be registered so it changes only on timer wrap.
REQ-024 At timer=CPP-1, SHALL register out_sample<=fir_out and pulse out_valid on the following cycle; this gives exactly OSF out_valid pulses per frame, spaced CPP clocks apart.
REQ-025 A frame boundary is timer=CPP-1 with phase=OSF-1; at that point:
  - enable=0: go to IDLE.
  - FIFO non-empty: pop, pulse FIR_en, set phase=0, stay in RUN.
  - FIFO empty: set underrun=1, then behave per REQ-033/REQ-034.
REQ-026 FIR_en SHALL be high only on the cycle a sample is loaded (or a zero is inserted), and never more than once per OSF*CPP clocks.
REQ-027 Deasserting enable mid-frame SHALL NOT truncate the frame; the remaining phases complete.
REQ-028 Input accepted while in RUN SHALL NOT affect the current frame.

Reset
REQ-029 While rst=1, SHALL set state=IDLE, FIFO empty, and phase=0, timer=0.
REQ-030 While rst=1, SHALL drive fir_in=0, FIR_en=0, FIR_sel=0, out_sample=0, out_valid=0, underrun=0, fifo_level=0, and in_ready=0.
REQ-031 rst asserted mid-frame SHALL abort immediately; no out_valid pulse on the cycle after reset.
REQ-032 underrun SHALL be cleared only by rst.

Configuration
REQ-033 With macro INTERP_FEED_CTRL_UNDERRUN_ZERO_EN defined, an empty FIFO at a frame boundary with enable=1 SHALL load fir_in=0, pulse FIR_en and continue in RUN, keeping the out_valid cadence unbroken.
REQ-034 Without INTERP_FEED_CTRL_UNDERRUN_ZERO_EN, an empty FIFO at a frame boundary SHALL go to IDLE; restart follows REQ-021.

Verification
REQ-035 Reset then single sample: push 0x4000, enable=1 -> FIR_en pulse 1 cycle after push, FIR_sel steps 0..15 every 8 clocks, 16 out_valid pulses.
REQ-036 Full FIFO: push 5 samples back-to-back while in IDLE with enable=0 -> in_ready=0 after 4 pushes, fifo_level=4, 5th sample not accepted.
REQ-037 Continuous stream: 3 samples pre-loaded -> FIR_en pulses exactly 128 clocks apart, 48 out_valid pulses, underrun=0 at the end.
REQ-038 Starvation: 1 sample with macro defined -> underrun=1 at clock 127, FIR_en pulses with fir_in=0, out_valid continues; without the macro -> FIR_sel=0 and out_valid stops after 16 pulses.
REQ-039 Mid-frame disturbance: drop enable at phase 5 -> phases 6..15 still complete, then IDLE; separately, rst at phase 9 -> all outputs 0 next cycle, underrun=0.
